// File: rtl/npu_core_vec.sv
// Multi-lane quantized NPU datapath: negate, add/mul/requantize, gain, rounding shift,
// offset and saturation through a 4-stage pipeline with valid/ready flow control.
module npu_core_vec #(
    parameter int DW    = 8,
    parameter int LANES = 4,
    parameter int GW    = 16
) (
    input  logic                  CLK,
    input  logic                  RESET_X,
    input  logic                  SOFT_RESET,
    input  logic [1:0]            OP,
    input  logic                  INV_ASEL,
    input  logic                  INV_BSEL,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [LANES*DW-1:0]   A_IN,
    input  logic [LANES*DW-1:0]   B_IN,
    input  logic [GW-1:0]         GAIN,
    input  logic [4:0]            SHIFT,
    input  logic [DW-1:0]         OFFSET,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [LANES*DW-1:0]   C_OUT,
    input  logic                  STAT_CLR,
    output logic [2*DW-1:0]       RMAX,
    output logic [2*DW-1:0]       RMIN,
    output logic [15:0]           SAT_CNT,
    output logic                  OP_ERR
);

    localparam int PW = 2 * DW;
    localparam int MW = PW + GW;
    localparam int RW = MW + 1;

    localparam logic signed [RW-1:0] V_MAX = RW'((2 ** (PW - 1)) - 1);
    localparam logic signed [RW-1:0] V_MIN = RW'(-(2 ** (PW - 1)));
    localparam logic signed [PW-1:0] C_MAX = PW'((2 ** (DW - 1)) - 1);
    localparam logic signed [PW-1:0] C_MIN = PW'(-(2 ** (DW - 1)));
    localparam logic signed [DW-1:0] D_MAX = C_MAX[DW-1:0];
    localparam logic signed [DW-1:0] D_MIN = C_MIN[DW-1:0];

    function automatic logic signed [DW-1:0] sat_neg(input logic signed [DW-1:0] x);
        return (x == D_MIN) ? D_MAX : -x;
    endfunction

    // Round half up, then arithmetic shift; one guard bit keeps the bias add from overflowing.
    function automatic logic signed [RW-1:0] round_shift(input logic signed [MW-1:0] m,
                                                         input logic [4:0] sh);
        logic signed [RW-1:0] half;
        half = (sh == 5'd0) ? '0 : (RW'(1) <<< (sh - 5'd1));
        return (RW'(m) + half) >>> sh;
    endfunction

    function automatic logic signed [PW-1:0] clamp_v(input logic signed [RW-1:0] x);
        if (x > V_MAX) return V_MAX[PW-1:0];
        if (x < V_MIN) return V_MIN[PW-1:0];
        return x[PW-1:0];
    endfunction

    function automatic logic signed [DW-1:0] clamp_c(input logic signed [PW-1:0] x);
        if (x > C_MAX) return C_MAX[DW-1:0];
        if (x < C_MIN) return C_MIN[DW-1:0];
        return x[DW-1:0];
    endfunction

    logic                  adv;
    logic                  vld_p1, vld_p2, vld_p3, vld_p4;

    logic signed [DW-1:0]  a_p1 [LANES];
    logic signed [DW-1:0]  b_p1 [LANES];
    logic [1:0]            op_p1;
    logic signed [GW-1:0]  gain_p1, gain_p2;
    logic [4:0]            shift_p1, shift_p2, shift_p3;
    logic signed [DW-1:0]  offset_p1, offset_p2, offset_p3;
    logic signed [PW-1:0]  p_p2 [LANES];
    logic                  rsv_p2, rsv_p3;
    logic signed [MW-1:0]  m_p3 [LANES];
    logic signed [PW-1:0]  v_p4 [LANES];
    logic signed [DW-1:0]  c_p4 [LANES];
    logic                  sat_p4 [LANES];

    logic signed [PW-1:0]  v_n [LANES];
    logic signed [DW-1:0]  c_n [LANES];
    logic                  sat_n [LANES];

    logic signed [PW-1:0]  rmax_q, rmin_q, bmax, bmin;
    logic [15:0]           sat_cnt_q, nsat, sat_next;
    logic [16:0]           cnt_sum;

    assign adv      = !OUT_VALID || OUT_READY;
    assign IN_READY = adv;
    assign RMAX     = rmax_q;
    assign RMIN     = rmin_q;
    assign SAT_CNT  = sat_cnt_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            v_n[i]   = clamp_v(round_shift(m_p3[i], shift_p3) + RW'(offset_p3));
            c_n[i]   = rsv_p3 ? '0 : clamp_c(v_n[i]);
            sat_n[i] = !rsv_p3 && (PW'(c_n[i]) != v_n[i]);
        end
    end

    always_comb begin
        bmax = v_p4[0];
        bmin = v_p4[0];
        nsat = '0;
        for (int i = 0; i < LANES; i++) begin
            if (v_p4[i] > bmax) bmax = v_p4[i];
            if (v_p4[i] < bmin) bmin = v_p4[i];
            if (sat_p4[i]) nsat = nsat + 16'd1;
        end
        cnt_sum  = {1'b0, sat_cnt_q} + {1'b0, nsat};
        sat_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge CLK) begin
        if (adv) begin
            // S1: capture with saturating negate
            for (int i = 0; i < LANES; i++) begin
                a_p1[i] <= INV_ASEL ? sat_neg(A_IN[i*DW +: DW]) : A_IN[i*DW +: DW];
                b_p1[i] <= INV_BSEL ? sat_neg(B_IN[i*DW +: DW]) : B_IN[i*DW +: DW];
            end
            op_p1     <= OP;
            gain_p1   <= GAIN;
            shift_p1  <= SHIFT;
            offset_p1 <= OFFSET;
            // S2: pre-op
            for (int i = 0; i < LANES; i++) begin
                case (op_p1)
                    2'b00:   p_p2[i] <= PW'(a_p1[i]) + PW'(b_p1[i]);
                    2'b01:   p_p2[i] <= PW'(a_p1[i]) * PW'(b_p1[i]);
                    2'b10:   p_p2[i] <= PW'(a_p1[i]);
                    default: p_p2[i] <= '0;
                endcase
            end
            rsv_p2    <= (op_p1 == 2'b11);
            gain_p2   <= gain_p1;
            shift_p2  <= shift_p1;
            offset_p2 <= offset_p1;
            // S3: gain
            for (int i = 0; i < LANES; i++) begin
                m_p3[i] <= MW'(p_p2[i]) * MW'(gain_p2);
            end
            rsv_p3    <= rsv_p2;
            shift_p3  <= shift_p2;
            offset_p3 <= offset_p2;
            // S4: round, offset, saturate
            v_p4   <= v_n;
            c_p4   <= c_n;
            sat_p4 <= sat_n;
        end
    end

    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            {vld_p1, vld_p2, vld_p3, vld_p4, OUT_VALID} <= '0;
            C_OUT     <= '0;
            OP_ERR    <= 1'b0;
            rmax_q    <= V_MIN[PW-1:0];
            rmin_q    <= V_MAX[PW-1:0];
            sat_cnt_q <= '0;
        end else if (SOFT_RESET) begin
            {vld_p1, vld_p2, vld_p3, vld_p4, OUT_VALID} <= '0;
            C_OUT     <= '0;
            OP_ERR    <= 1'b0;
            rmax_q    <= V_MIN[PW-1:0];
            rmin_q    <= V_MAX[PW-1:0];
            sat_cnt_q <= '0;
        end else begin
            if (adv) begin
                vld_p1    <= IN_VALID;
                vld_p2    <= vld_p1;
                vld_p3    <= vld_p2;
                vld_p4    <= vld_p3;
                OUT_VALID <= vld_p4;
                if (vld_p4) begin
                    for (int i = 0; i < LANES; i++) C_OUT[i*DW +: DW] <= c_p4[i];
                end
                if (vld_p1 && op_p1 == 2'b11) OP_ERR <= 1'b1;
            end
            // A clear in the same cycle as an update drops that beat's contribution.
            if (STAT_CLR) begin
                rmax_q    <= V_MIN[PW-1:0];
                rmin_q    <= V_MAX[PW-1:0];
                sat_cnt_q <= '0;
            end else if (adv && vld_p4) begin
                rmax_q    <= (bmax > rmax_q) ? bmax : rmax_q;
                rmin_q    <= (bmin < rmin_q) ? bmin : rmin_q;
                sat_cnt_q <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_npu_core_vec.sv
// Scoreboard bench for npu_core_vec: directed and random beats against an integer reference model.
module tb_npu_core_vec;

    localparam int DW = 8;
    localparam int LANES = 4;
    localparam int GW = 16;
    localparam int PW = 2 * DW;

    logic                CLK = 1'b0;
    logic                RESET_X, SOFT_RESET, INV_ASEL, INV_BSEL, IN_VALID, IN_READY;
    logic [1:0]          OP;
    logic [LANES*DW-1:0] A_IN, B_IN, C_OUT;
    logic [GW-1:0]       GAIN;
    logic [4:0]          SHIFT;
    logic [DW-1:0]       OFFSET;
    logic                OUT_VALID, OUT_READY, STAT_CLR, OP_ERR;
    logic [PW-1:0]       RMAX, RMIN;
    logic [15:0]         SAT_CNT;

    npu_core_vec #(.DW(DW), .LANES(LANES), .GW(GW)) dut (
        .CLK(CLK), .RESET_X(RESET_X), .SOFT_RESET(SOFT_RESET), .OP(OP),
        .INV_ASEL(INV_ASEL), .INV_BSEL(INV_BSEL), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A_IN(A_IN), .B_IN(B_IN), .GAIN(GAIN), .SHIFT(SHIFT), .OFFSET(OFFSET),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .C_OUT(C_OUT), .STAT_CLR(STAT_CLR),
        .RMAX(RMAX), .RMIN(RMIN), .SAT_CNT(SAT_CNT), .OP_ERR(OP_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [LANES*DW-1:0] c;
        logic [LANES*PW-1:0] v;
        int                  nsat;
        bit                  drop;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint mrmax, mrmin, msat;
    bit     rnd_en;

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, expv, expv);
        end
    endtask

    task automatic model_stats_reset();
        mrmax = -(64'sd1 <<< (PW - 1));
        mrmin = (64'sd1 <<< (PW - 1)) - 1;
        msat  = 0;
    endtask

    function automatic longint clampl(input longint x, input longint lo, input longint hi);
        return (x < lo) ? lo : (x > hi) ? hi : x;
    endfunction

    function automatic longint sneg(input longint x);
        return (x == -(64'sd1 <<< (DW - 1))) ? (64'sd1 <<< (DW - 1)) - 1 : -x;
    endfunction

    // Reference: integer arithmetic, floor division for the rounded shift.
    function automatic exp_t model(input logic [1:0] op, input bit ia, input bit ib,
                                   input logic [LANES*DW-1:0] av, input logic [LANES*DW-1:0] bv,
                                   input logic [GW-1:0] g, input logic [4:0] s,
                                   input logic [DW-1:0] o);
        exp_t e;
        longint x, y, p, m, t, d, r, v, c;
        e.nsat = 0;
        e.drop = 1'b0;
        e.c = '0;
        e.v = '0;
        for (int i = 0; i < LANES; i++) begin
            x = longint'($signed(av[i*DW +: DW]));
            y = longint'($signed(bv[i*DW +: DW]));
            if (ia) x = sneg(x);
            if (ib) y = sneg(y);
            case (op)
                2'd0: p = x + y;
                2'd1: p = x * y;
                2'd2: p = x;
                default: p = 0;
            endcase
            m = p * longint'($signed(g));
            d = 64'sd1 <<< s;
            t = m + ((s > 0) ? (d / 2) : 0);
            r = (t >= 0) ? (t / d) : -((-t + d - 1) / d);
            v = clampl(r + longint'($signed(o)), -32768, 32767);
            c = (op == 2'd3) ? 0 : clampl(v, -128, 127);
            if (op != 2'd3 && c != v) e.nsat++;
            e.c[i*DW +: DW] = c[DW-1:0];
            e.v[i*PW +: PW] = v[PW-1:0];
        end
        return e;
    endfunction

    function automatic logic [LANES*DW-1:0] rep(input int val);
        logic [DW-1:0] t;
        t = val[DW-1:0];
        return {LANES{t}};
    endfunction

    // Monitor: pops an expectation on every output transfer.
    always @(negedge CLK) begin
        exp_t e;
        longint vv;
        if (OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: output beat 0x%0h with no beat outstanding", C_OUT);
            end else begin
                e = sb.pop_front();
                chk("c_out", C_OUT, e.c);
                if (e.drop) model_stats_reset();
                else begin
                    for (int i = 0; i < LANES; i++) begin
                        vv = longint'($signed(e.v[i*PW +: PW]));
                        if (vv > mrmax) mrmax = vv;
                        if (vv < mrmin) mrmin = vv;
                    end
                    msat = msat + e.nsat;
                    if (msat > 65535) msat = 65535;
                end
                chk("rmax", longint'($signed(RMAX)), mrmax);
                chk("rmin", longint'($signed(RMIN)), mrmin);
                chk("sat_cnt", SAT_CNT, msat);
            end
        end
    end

    task automatic send(input logic [1:0] op, input bit ia, input bit ib,
                        input logic [LANES*DW-1:0] av, input logic [LANES*DW-1:0] bv,
                        input logic [GW-1:0] g, input logic [4:0] s, input logic [DW-1:0] o,
                        input bit drop);
        exp_t e;
        int w;
        OP = op; INV_ASEL = ia; INV_BSEL = ib; A_IN = av; B_IN = bv;
        GAIN = g; SHIFT = s; OFFSET = o; IN_VALID = 1'b1;
        e = model(op, ia, ib, av, bv, g, s, o);
        e.drop = drop;
        w = 0;
        @(negedge CLK);
        while (!IN_READY && w < 200) begin
            @(negedge CLK);
            w++;
        end
        if (!IN_READY) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: IN_READY still %0d after %0d cycles, expected 1", IN_READY, w);
        end else sb.push_back(e);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic wait_out(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!OUT_VALID && n < 20);
        chk(nm, n, 4);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(posedge CLK);
            #1;
            w++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, OUT_VALID, 0);
        chk({tag, "_sat_cnt"}, SAT_CNT, 0);
        chk({tag, "_op_err"}, OP_ERR, 0);
        chk({tag, "_rmax"}, longint'($signed(RMAX)), -32768);
        chk({tag, "_rmin"}, longint'($signed(RMIN)), 32767);
    endtask

    initial begin
        int n;
        RESET_X = 1'b0; SOFT_RESET = 1'b0; STAT_CLR = 1'b0; OP = '0;
        INV_ASEL = 1'b0; INV_BSEL = 1'b0; IN_VALID = 1'b0; A_IN = '0; B_IN = '0;
        GAIN = '0; SHIFT = '0; OFFSET = '0; OUT_READY = 1'b1; rnd_en = 1'b0;
        model_stats_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET_X = 1'b1;
        @(posedge CLK);
        #1;
        check_reset_state("reset");
        chk("reset_c_out", C_OUT, 0);
        chk("reset_in_ready", IN_READY, 1);

        // ADD rounding, first beat also measures latency
        send(2'd0, 0, 0, rep(10), rep(20), 16'd16384, 5'd15, 8'd0, 0);
        wait_out("latency_first");
        send(2'd0, 0, 0, rep(1), rep(0), 16'd16384, 5'd15, 8'd0, 0);
        send(2'd0, 0, 0, rep(-1), rep(0), 16'd16384, 5'd15, 8'd0, 0);
        // MUL saturation on all lanes
        send(2'd1, 0, 0, rep(100), rep(100), 16'd1, 5'd0, 8'd0, 0);
        drain();
        chk("mul_sat_cnt", SAT_CNT, 4);
        chk("mul_rmax", longint'($signed(RMAX)), 10000);
        STAT_CLR = 1'b1;
        @(posedge CLK);
        #1;
        STAT_CLR = 1'b0;
        model_stats_reset();
        chk("clr_rmax", longint'($signed(RMAX)), -32768);
        chk("clr_rmin", longint'($signed(RMIN)), 32767);
        chk("clr_sat_cnt", SAT_CNT, 0);

        // Inversion and requantize
        send(2'd2, 1, 0, rep(-128), rep(0), 16'd1, 5'd0, -8'sd7, 0);
        send(2'd2, 0, 0, rep(5), rep(0), 16'd1, 5'd0, -8'sd7, 0);
        drain();
        chk("op_err_before", OP_ERR, 0);

        // Reserved op between two ADD beats
        send(2'd0, 0, 0, rep(3), rep(4), 16'd1, 5'd0, 8'd0, 0);
        send(2'd3, 0, 0, rep(77), rep(9), 16'd1, 5'd0, 8'd0, 0);
        send(2'd0, 0, 1, rep(-6), rep(-128), 16'd1, 5'd0, 8'd2, 0);
        drain();
        chk("op_err_set", OP_ERR, 1);

        // STAT_CLR coinciding with the beat's statistics update
        send(2'd0, 0, 0, rep(50), rep(50), 16'd1, 5'd0, 8'd0, 1);
        repeat (3) @(posedge CLK);
        #1;
        STAT_CLR = 1'b1;
        @(posedge CLK);
        #1;
        STAT_CLR = 1'b0;
        drain();

        // Backpressure: 10 back-to-back beats, 3-cycle output stall
        fork
            begin
                for (int k = 0; k < 10; k++)
                    send(2'd0, 0, 0, rep(k), rep(0), 16'd1, 5'd0, 8'd0, 0);
            end
            begin
                int w;
                w = 0;
                while (!OUT_VALID && w < 50) begin
                    @(posedge CLK);
                    #1;
                    w++;
                end
                OUT_READY = 1'b0;
                repeat (3) begin
                    @(negedge CLK);
                    chk("in_ready_hold", IN_READY, 0);
                    @(posedge CLK);
                    #1;
                end
                OUT_READY = 1'b1;
            end
        join
        drain();

        // Random traffic with random backpressure
        rnd_en = 1'b1;
        fork
            begin
                logic [1:0] op;
                int g;
                for (int k = 0; k < 300; k++) begin
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin
                        @(posedge CLK);
                        #1;
                    end
                    op = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                    g = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 8)) - 4;
                    send(op, 1'($urandom), 1'($urandom), $urandom, $urandom, g[GW-1:0],
                         5'($urandom_range(0, 31)), (op == 2'd3) ? 8'd0 : 8'($urandom), 0);
                end
                rnd_en = 1'b0;
            end
            begin
                while (rnd_en) begin
                    @(posedge CLK);
                    #1;
                    OUT_READY = ($urandom_range(0, 3) != 0);
                end
            end
        join
        OUT_READY = 1'b1;
        drain();
        chk("op_err_sticky", OP_ERR, 1);

        // Drive the saturation counter into its sticky ceiling
        n = int'((65535 - msat) / 4) + 4;
        for (int k = 0; k < n; k++)
            send(2'd1, 0, 0, rep(100), rep(100), 16'd1, 5'd0, 8'd0, 0);
        drain();
        chk("sat_cnt_sticky", SAT_CNT, 16'hFFFF);

        SOFT_RESET = 1'b1;
        @(posedge CLK);
        #1;
        SOFT_RESET = 1'b0;
        model_stats_reset();
        check_reset_state("soft");

        // Reset with three beats in flight
        send(2'd0, 0, 0, rep(3), rep(4), 16'd1, 5'd0, 8'd0, 0);
        drain();
        for (int k = 0; k < 3; k++)
            send(2'd1, 0, 0, rep(k + 2), rep(7), 16'd3, 5'd1, 8'd1, 0);
        RESET_X = 1'b0;
        sb.delete();
        model_stats_reset();
        #2;
        check_reset_state("async");
        @(negedge CLK);
        RESET_X = 1'b1;
        @(posedge CLK);
        #1;
        send(2'd0, 0, 0, rep(-20), rep(5), 16'd3, 5'd2, 8'd4, 0);
        wait_out("latency_after_reset");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
